// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 SDF FFT chain: data widths, the
// runtime-length bit-reversal helper and the output reorder reader states.
package fft_pkg;

  localparam int FLOAT_LEN = 32;
  localparam int DATA_W    = 2 * FLOAT_LEN;
  localparam int LOG2N_MAX = 13;
  localparam int BITREV_W  = 16;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_t;

  // Reverses the low log2n bits of v; the bits above log2n come back as zero.
  function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] v,
                                                 input logic [3:0]          log2n);
    logic [BITREV_W-1:0] full_rev;
    full_rev = {<<{v}};
    return full_rev >> (5'(BITREV_W) - {1'b0, log2n});
  endfunction

  function automatic logic [BITREV_W-1:0] last_index(input logic [3:0] log2n);
    return (BITREV_W'(1) << log2n) - BITREV_W'(1);
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Sample stream into and out of the FFT output reorder stage.
interface fft_out_reorder_if #(
  parameter int DATA_W    = fft_pkg::DATA_W,
  parameter int LOG2N_MAX = fft_pkg::LOG2N_MAX
);
  logic                 din_valid;
  logic [DATA_W-1:0]    din;
  logic                 dout_valid;
  logic [DATA_W-1:0]    dout;
  logic [LOG2N_MAX-1:0] dout_index;
  logic                 dout_finish;

  modport master (
    output din_valid, din,
    input  dout_valid, dout, dout_index, dout_finish
  );

  modport slave (
    input  din_valid, din,
    output dout_valid, dout, dout_index, dout_finish
  );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank simple dual-port sample buffer, address = {bank, addr}, one-cycle
// registered read. Written as a plain array so it maps onto block RAM.
module fft_pingpong_ram #(
  parameter int DATA_W    = 64,
  parameter int LOG2N_MAX = 13
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LOG2N_MAX:0]   waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 re,
  input  logic [LOG2N_MAX:0]   raddr,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [2**(LOG2N_MAX+1)];

  // NOTE: the array and its read register have no reset; a reset port would
  // stop the RAM from mapping onto block RAM, and stale data is never exposed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Output stage of the SDF FFT: writes the bit-reversed stream into one bank of
// a ping-pong buffer while the other bank is read back in natural order.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int DATA_W    = fft_pkg::DATA_W,
  parameter int LOG2N_MAX = fft_pkg::LOG2N_MAX,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cfg_log2n,
  fft_out_reorder_if.slave  io,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              overflow,
  output logic              busy
);

  localparam logic [3:0] LOG2N_HI = 4'(LOG2N_MAX);
  localparam logic [3:0] LOG2N_LO = 4'd3;

  logic [1:0]           full;
  logic                 wr_bank, rd_bank;
  logic [LOG2N_MAX-1:0] wr_cnt, rd_cnt;
  logic [3:0]           bank_log2n [2];
  rd_state_t            state, state_nx;

  logic [3:0]           cfg_clamped, wr_log2n, rd_log2n;
  logic                 wr_en, wr_last, rd_issue, rd_done, rd_last;
  logic [LOG2N_MAX:0]   wr_addr;
  logic [DATA_W-1:0]    ram_q;
  logic                 dout_valid_q, dout_finish_q;
  logic [LOG2N_MAX-1:0] dout_index_q;

  // ---------------- write side ----------------
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cfg_clamped = cfg_log2n;
    if (cfg_log2n < LOG2N_LO) cfg_clamped = LOG2N_LO;
    else if (cfg_log2n > LOG2N_HI) cfg_clamped = LOG2N_HI;
  end

  // The length only comes from cfg_log2n on the first sample of a frame.
  assign wr_log2n = (wr_cnt == '0) ? cfg_clamped : bank_log2n[wr_bank];
  assign wr_last  = (wr_cnt == LOG2N_MAX'(last_index(wr_log2n)));
  assign wr_en    = io.din_valid && !full[wr_bank];
  assign wr_addr  = {wr_bank, LOG2N_MAX'(bitrev(BITREV_W'(wr_cnt), wr_log2n))};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank       <= 1'b0;
      wr_cnt        <= '0;
      overflow      <= 1'b0;
      bank_log2n[0] <= LOG2N_LO;
      bank_log2n[1] <= LOG2N_LO;
    end else if (wr_en) begin
      if (wr_cnt == '0) bank_log2n[wr_bank] <= wr_log2n;
      if (wr_last) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt <= wr_cnt + LOG2N_MAX'(1);
      end
    end else if (io.din_valid) begin
      overflow <= 1'b1;
    end
  end

  // The writer only fills an empty bank and the reader only drains a full
  // one, so the set and the clear below never target the same bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (rd_done)          full[rd_bank] <= 1'b0;
      if (wr_en && wr_last) full[wr_bank] <= 1'b1;
    end
  end

  // ---------------- read side ----------------
  assign rd_log2n = bank_log2n[rd_bank];
  assign rd_last  = (rd_cnt == LOG2N_MAX'(last_index(rd_log2n)));

  always_comb begin
    state_nx = state;
    rd_issue = 1'b0;
    rd_done  = 1'b0;
    case (state)
      RD_IDLE: if (full[rd_bank]) state_nx = RD_RUN;
      RD_RUN: begin
        rd_issue = 1'b1;
        if (rd_last) begin
          rd_done  = 1'b1;
          state_nx = full[~rd_bank] ? RD_RUN : RD_IDLE;
        end
      end
      default: state_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (rd_issue) rd_cnt <= rd_last ? '0 : rd_cnt + LOG2N_MAX'(1);
      if (rd_done)  rd_bank <= ~rd_bank;
    end
  end

  fft_pingpong_ram #(
    .DATA_W    (DATA_W),
    .LOG2N_MAX (LOG2N_MAX)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (io.din),
    .re    (rd_issue),
    .raddr ({rd_bank, rd_cnt}),
    .rdata (ram_q)
  );

  // Sideband is registered at the issue edge so it lines up with the RAM output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid_q  <= 1'b0;
      dout_finish_q <= 1'b0;
      dout_index_q  <= '0;
      frame_cnt     <= '0;
    end else begin
      dout_valid_q  <= rd_issue;
      dout_finish_q <= rd_done;
      if (rd_issue) dout_index_q <= rd_cnt;
      if (rd_done)  frame_cnt <= frame_cnt + FCNT_W'(1);
    end
  end

  assign io.dout_valid  = dout_valid_q;
  assign io.dout_finish = dout_finish_q;
  assign io.dout_index  = dout_index_q;
  assign io.dout        = dout_valid_q ? ram_q : '0;

  assign busy = (|full) || (state == RD_RUN);

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: random and ramp frames compared
// against a reference built from the natural-order / bit-reversal definition.
module tb_fft_out_reorder;

  localparam int DW = 64;
  localparam int LN = 13;
  localparam int FW = 16;

  typedef struct {
    int          idx;
    logic [63:0] data;
    bit          fin;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    cfg_log2n;
  logic [FW-1:0] frame_cnt;
  logic          overflow, busy;

  fft_out_reorder_if #(.DATA_W(DW), .LOG2N_MAX(LN)) io ();

  fft_out_reorder #(.DATA_W(DW), .LOG2N_MAX(LN), .FCNT_W(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_log2n (cfg_log2n),
    .io        (io.slave),
    .frame_cnt (frame_cnt),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  longint      cyc = 0;
  exp_t        exp_q[$];
  logic [63:0] obs_q[$];
  int          exp_frames = 0;
  int          run_len = 0;
  int          max_run = 0;
  bit          first_seen = 1'b0;
  longint      first_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Natural-order index k is held by input sample j whose bit pattern is k reversed.
  function automatic int ref_rev(input int k, input int log2n);
    int r = 0;
    for (int b = 0; b < log2n; b++) r = (r << 1) | ((k >> b) & 1);
    return r;
  endfunction

  task automatic push_frame(input int log2n, input logic [63:0] s[$]);
    int n = 1 << log2n;
    for (int k = 0; k < n; k++) exp_q.push_back('{k, s[ref_rev(k, log2n)], k == n - 1});
    exp_frames++;
  endtask

  task automatic gen_random(input int n, output logic [63:0] s[$]);
    s = {};
    for (int i = 0; i < n; i++) s.push_back({$urandom, $urandom});
  endtask

  task automatic drive(input bit v, input logic [63:0] d);
    io.din_valid = v;
    io.din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] s[$]);
    foreach (s[i]) drive(1'b1, s[i]);
    drive(1'b0, '0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((busy || io.dout_valid || exp_q.size() != 0) && n < 30000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_timeout"}, 128'(n < 30000), 128'(1));
    check({tag, "_leftover"}, 128'(exp_q.size()), 128'(0));
    check({tag, "_frame_cnt"}, 128'(frame_cnt), 128'(exp_frames));
  endtask

  task automatic check_reset_state(input string tag);
    check(tag, 128'({io.dout_valid, io.dout, io.dout_index, io.dout_finish,
                     frame_cnt, overflow, busy}), 128'(0));
  endtask

  // Output monitor: every valid output is matched against the reference queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (io.dout_valid) begin
          run_len++;
          if (run_len > max_run) max_run = run_len;
          if (!first_seen) begin
            first_seen = 1'b1;
            first_cyc  = cyc;
          end
          obs_q.push_back(io.dout);
          if (exp_q.size() == 0) begin
            check("unexpected_out", 128'(1), 128'(0));
          end else begin
            e = exp_q.pop_front();
            check("dout_index", 128'(io.dout_index), 128'(e.idx));
            check("dout", 128'(io.dout), 128'(e.data));
            check("dout_finish", 128'(io.dout_finish), 128'(e.fin));
          end
        end else begin
          run_len = 0;
          check("finish_idle", 128'(io.dout_finish), 128'(0));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] s[$];
    logic [63:0] s2[$];
    int          ramp_exp[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    longint      last_edge;

    rst          = 1'b1;
    cfg_log2n    = 4'd3;
    io.din_valid = 1'b0;
    io.din       = '0;
    repeat (3) @(negedge clk);
    check_reset_state("por_reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 8-point ramp: bit-reversed readback and two-cycle output latency.
    s = {};
    for (int i = 0; i < 8; i++) s.push_back(64'(i));
    push_frame(3, s);
    obs_q = {};
    foreach (s[i]) drive(1'b1, s[i]);
    last_edge = cyc;
    drive(1'b0, '0);
    wait_drain("ramp8");
    check("ramp8_first_latency", 128'(first_cyc - last_edge), 128'(2));
    check("ramp8_count", 128'(obs_q.size()), 128'(8));
    for (int i = 0; i < 8; i++)
      if (i < obs_q.size()) check("ramp8_value", 128'(obs_q[i]), 128'(ramp_exp[i]));

    // Two back-to-back full-size frames of a bit-reversed ramp: gap-free output.
    cfg_log2n = 4'd13;
    s = {};
    for (int f = 0; f < 2; f++)
      for (int j = 0; j < 8192; j++) s.push_back(64'(f * 8192 + ref_rev(j, 13)));
    s2 = s[0:8191];
    push_frame(13, s2);
    s2 = s[8192:16383];
    push_frame(13, s2);
    max_run = 0;
    foreach (s[i]) drive(1'b1, s[i]);
    drive(1'b0, '0);
    check("b2b_busy", 128'(busy), 128'(1));
    wait_drain("b2b");
    check("b2b_max_run", 128'(max_run), 128'(16384));
    check("b2b_overflow", 128'(overflow), 128'(0));

    // Out-of-range length clamps to the maximum; a mid-frame length change is
    // ignored until the next frame, which is then 8 points.
    cfg_log2n = 4'd15;
    gen_random(8192, s);
    gen_random(8, s2);
    push_frame(13, s);
    push_frame(3, s2);
    foreach (s[i]) begin
      if (i == 100) cfg_log2n = 4'd3;
      drive(1'b1, s[i]);
    end
    send(s2);
    wait_drain("len_change");
    check("len_change_overflow", 128'(overflow), 128'(0));

    // Overflow: a long frame drains while short frames arrive; the second short
    // frame finds its bank still full and is dropped entirely.
    cfg_log2n = 4'd13;
    gen_random(8192, s);
    push_frame(13, s);
    foreach (s[i]) drive(1'b1, s[i]);
    cfg_log2n = 4'd3;
    gen_random(8, s2);
    push_frame(3, s2);
    foreach (s2[i]) drive(1'b1, s2[i]);
    check("ovf_before_drop", 128'(overflow), 128'(0));
    gen_random(8, s2);
    send(s2);
    check("ovf_after_drop", 128'(overflow), 128'(1));
    wait_drain("ovf");
    check("ovf_sticky", 128'(overflow), 128'(1));

    // Reset in the middle of a frame discards it; only the next frame appears.
    cfg_log2n = 4'd13;
    gen_random(50, s);
    foreach (s[i]) drive(1'b1, s[i]);
    io.din_valid = 1'b0;
    rst          = 1'b1;
    exp_q        = {};
    exp_frames   = 0;
    repeat (2) begin
      @(negedge clk);
      check_reset_state("mid_reset_state");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cfg_log2n = 4'd3;
    obs_q = {};
    gen_random(8, s);
    push_frame(3, s);
    send(s);
    wait_drain("post_reset");
    check("post_reset_count", 128'(obs_q.size()), 128'(8));
    check("post_reset_overflow", 128'(overflow), 128'(0));
    check("post_reset_idle", 128'(busy), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
